tdm_demux_1to8: RTL and testbench
=================================

// Module: tdm_demux_1to8
// PURPOSE
//  Receive-side counterpart of the 8:1 data selector: a 1:8 time-division demultiplexer.
//  Takes one serial slot stream (slot 0 flagged by fsync) and steers each beat to one of 8 registered lanes.
//  Counts slots, tracks frame alignment, and flags complete frames.
//  Sits between a TDM link and the per-channel consumers.
// PARAMETERS
//  W      1   data width per slot/lane (bits), >=1
// PORTS
//  clk       in   1     rising-edge clock
//  rst       in   1     synchronous reset, active-high
//  din       in   W     slot data beat
//  din_vld   in   1     beat valid; beats are accepted only when high
//  fsync     in   1     qualified by din_vld; marks the current beat as slot 0
//  dout      out  8*W   lane registers; lane k = dout[k*W +: W]
//  lane_vld  out  8     1-cycle pulse on bit k when lane k is updated
//  frame_vld out  1     1-cycle pulse: slots 0..7 of one frame all captured
//  slot      out  3     index of next expected slot
//  locked    out  1     high in TRACK state
//  sync_err  out  1     1-cycle pulse on an alignment error
// BEHAVIOUR
//  Reset: dout=0, lane_vld=0, frame_vld=0, slot=0, locked=0, sync_err=0, state=HUNT.
//  Reset mid-frame abandons the partial frame; no pulses are issued for it.
//  Latency: beat accepted at edge N -> dout/lane_vld updated after edge N (visible cycle N+1).
//  frame_vld is asserted in the same cycle as lane_vld[7] for the completing beat.
//  No beat (din_vld=0): all state holds; lane_vld, frame_vld and sync_err are 0.
//  FSM HUNT:
//   - Beat with fsync=1: write lane 0, slot<=1, go TRACK.
//   - Beat with fsync=0: dropped, no error.
//  FSM TRACK:
//   - Beat at slot s with fsync=0 and s!=0: write lane s, slot<=s+1 (3-bit wrap 7->0).
//   - Beat at slot 7: writes lane 7, pulses frame_vld, slot wraps to 0.
//   - fsync=1 at slot 0: normal start of the next frame; write lane 0, slot<=1.
//   - fsync=1 at slot!=0 (early sync): pulse sync_err and treat the beat as slot 0.
//     Write lane 0, slot<=1, stay TRACK; the partial frame never produces frame_vld.
//   - fsync=0 at slot 0 (missing sync): pulse sync_err, drop the beat, slot<=0, go HUNT.
//  Unwritten lanes keep their previous values; dout is never cleared except by rst.
//  frame_vld requires 8 consecutive accepted beats of one aligned frame, starting at slot 0.
//  locked = (state==TRACK).
// CONFIGURATION
//  TDM_DEMUX_PARITY_EN defined:
//   - Adds input din_par (1): even parity over {din, din_par}.
//   - Adds output par_err (1): pulses 1 cycle after a bad beat.
//   - A bad beat advances slot and follows all FSM rules, but does not write its lane or pulse lane_vld.
//   - A frame containing any bad beat suppresses its frame_vld.
//  TDM_DEMUX_PARITY_EN undefined:
//   - Neither port exists; every accepted beat is written.
// TESTING
//  1. rst=1 for 2 cycles, then idle -> all outputs 0, locked=0.
//  2. W=8, beats 0x10..0x17 with fsync on the first -> dout={17,...,10}.
//     lane_vld walks bit0..bit7; frame_vld=1 with lane_vld[7]; slot=0.
//  3. Beats 0xAA,0xBB with fsync=0 in HUNT -> dropped.
//     Then fsync beat 0x01 -> lane0=0x01, locked=1, slot=1.
//  4. Lock, send 3 beats, then fsync beat 0x55 -> sync_err pulse, lane0=0x55, slot=1.
//     No frame_vld until 7 more beats arrive.
//  5. Full frame, then next beat at slot 0 with fsync=0 -> sync_err pulse, locked=0, lane0 unchanged.
//     rst asserted mid-frame -> all outputs back to reset values.
//  6. PARITY_EN: frame with a bad parity bit on slot 3 -> par_err pulse, lane3 unchanged, lane_vld[3]=0.
//     frame_vld suppressed; the next clean frame gives frame_vld=1.

Source files
------------

// File: rtl/tdm_demux_1to8_if.sv
// Bus bundle for the 1:8 TDM demultiplexer.
// The link side uses the master modport and the demultiplexer uses the slave modport.
// Optional build macro: TDM_DEMUX_PARITY_EN adds din_par and par_err.
interface tdm_demux_1to8_if #(
    parameter int unsigned W = 1
) ();
    logic [W-1:0]   din;
    logic           din_vld;
    logic           fsync;
    logic [8*W-1:0] dout;
    logic [7:0]     lane_vld;
    logic           frame_vld;
    logic [2:0]     slot;
    logic           locked;
    logic           sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic           din_par;
    logic           par_err;

    modport master (
        output din, din_vld, fsync, din_par,
        input  dout, lane_vld, frame_vld, slot, locked, sync_err, par_err
    );
    modport slave (
        input  din, din_vld, fsync, din_par,
        output dout, lane_vld, frame_vld, slot, locked, sync_err, par_err
    );
`else
    modport master (
        output din, din_vld, fsync,
        input  dout, lane_vld, frame_vld, slot, locked, sync_err
    );
    modport slave (
        input  din, din_vld, fsync,
        output dout, lane_vld, frame_vld, slot, locked, sync_err
    );
`endif
endinterface

// File: rtl/tdm_demux_1to8.sv
// 1:8 time-division demultiplexer: steers each accepted slot beat into one of eight
// registered lanes, tracks frame alignment (HUNT/TRACK) and flags complete frames.
// Optional build macro: TDM_DEMUX_PARITY_EN (even parity per beat, par_err output,
// bad beats advance the slot but are not written and kill their frame's frame_vld).
module tdm_demux_1to8 #(
    parameter int unsigned W = 1
) (
    input logic             clk,
    input logic             rst,
    tdm_demux_1to8_if.slave bus
);
    typedef enum logic {StHunt, StTrack} state_e;

    state_e         state_q, state_d;
    logic [2:0]     slot_q, slot_d;
    logic [8*W-1:0] dout_q;
    logic [7:0]     lane_vld_q;
    logic           frame_vld_q;
    logic           sync_err_q, sync_err_d;
    logic           wr_en;
    logic [2:0]     wr_lane;
    logic           beat_ok;

`ifdef TDM_DEMUX_PARITY_EN
    logic           par_err_q;
    logic           frame_bad_q;

    // Even parity: XOR over data and parity bit must be zero.
    assign beat_ok     = ~^{bus.din, bus.din_par};
    assign bus.par_err = par_err_q;
`else
    assign beat_ok = 1'b1;
`endif

    // Alignment decisions for the current beat; a lane-0 write always opens a new frame.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        sync_err_d = 1'b0;
        wr_en      = 1'b0;
        wr_lane    = slot_q;
        if (bus.din_vld) begin
            unique case (state_q)
                StHunt: begin
                    if (bus.fsync) begin
                        wr_en   = 1'b1;
                        wr_lane = 3'd0;
                        slot_d  = 3'd1;
                        state_d = StTrack;
                    end
                end
                StTrack: begin
                    if (bus.fsync) begin
                        // Early sync resynchronises onto this beat as slot 0.
                        wr_en      = 1'b1;
                        wr_lane    = 3'd0;
                        slot_d     = 3'd1;
                        sync_err_d = (slot_q != 3'd0);
                    end else if (slot_q == 3'd0) begin
                        // Missing sync: drop the beat and go hunting again.
                        sync_err_d = 1'b1;
                        slot_d     = 3'd0;
                        state_d    = StHunt;
                    end else begin
                        wr_en   = 1'b1;
                        wr_lane = slot_q;
                        slot_d  = slot_q + 3'd1;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    // State, lane registers and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StHunt;
            slot_q      <= 3'd0;
            dout_q      <= '0;
            lane_vld_q  <= 8'd0;
            frame_vld_q <= 1'b0;
            sync_err_q  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q   <= 1'b0;
            frame_bad_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            sync_err_q  <= sync_err_d;
            lane_vld_q  <= 8'd0;
            for (int k = 0; k < 8; k++) begin
                if (wr_en && beat_ok && (wr_lane == 3'(k))) begin
                    dout_q[k*W +: W] <= bus.din;
                    lane_vld_q[k]    <= 1'b1;
                end
            end
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q   <= bus.din_vld && !beat_ok;
            frame_vld_q <= wr_en && (wr_lane == 3'd7) && beat_ok && !frame_bad_q;
            if (wr_en) begin
                frame_bad_q <= (wr_lane == 3'd0) ? !beat_ok : (frame_bad_q || !beat_ok);
            end
`else
            frame_vld_q <= wr_en && (wr_lane == 3'd7);
`endif
        end
    end

    assign bus.dout      = dout_q;
    assign bus.lane_vld  = lane_vld_q;
    assign bus.frame_vld = frame_vld_q;
    assign bus.slot      = slot_q;
    assign bus.locked    = (state_q == StTrack);
    assign bus.sync_err  = sync_err_q;
endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Table-driven bench for tdm_demux_1to8 with W=8; each row's expectations go through a
// scoreboard queue and are compared one cycle after the beat is presented.
// Optional build macro: TDM_DEMUX_PARITY_EN enables the parity rows and par_err checks.
module tb_tdm_demux_1to8;
    localparam int unsigned W = 8;

    typedef struct {
        logic        rst;
        logic        vld;
        logic        fs;
        logic [7:0]  din;
        logic        bad;
        logic [7:0]  e_lv;
        logic        e_fv;
        logic [2:0]  e_slot;
        logic        e_lk;
        logic        e_se;
        logic        e_pe;
        logic [2:0]  e_lane;
        logic [7:0]  e_val;
        logic        chk_dout;
        logic [63:0] e_dout;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    tdm_demux_1to8_if #(.W(W)) bus_if ();

    tdm_demux_1to8 #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic v, input logic f, input logic [7:0] d,
                                input logic b, input logic [7:0] lv, input logic fv,
                                input logic [2:0] sl, input logic lk, input logic se,
                                input logic pe, input logic [2:0] ln, input logic [7:0] val);
        vec_t x;
        x.rst = r; x.vld = v; x.fs = f; x.din = d; x.bad = b;
        x.e_lv = lv; x.e_fv = fv; x.e_slot = sl; x.e_lk = lk; x.e_se = se; x.e_pe = pe;
        x.e_lane = ln; x.e_val = val; x.chk_dout = 1'b0; x.e_dout = '0;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        vec_t e;
        logic [2:0] lane;

        // Reset and idle
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 3'd0, 0, 0, 0, 3'd0, 8'h00));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 3'd0, 0, 0, 0, 3'd0, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 3'd0, 0, 0, 0, 3'd0, 8'h00));
        // Full aligned frame 0x10..0x17
        for (int k = 0; k < 8; k++) begin
            v = mk(0, 1, k == 0, 8'(8'h10 + k), 0, 8'(1 << k), k == 7, 3'(k + 1), 1, 0, 0,
                   3'(k), 8'(8'h10 + k));
            if (k == 7) begin
                v.chk_dout = 1'b1;
                v.e_dout   = 64'h1716_1514_1312_1110;
            end
            vecs.push_back(v);
        end
        vecs.push_back(mk(0, 0, 0, 8'hFF, 0, 8'h00, 0, 3'd0, 1, 0, 0, 3'd3, 8'h13));
        // Missing sync at slot 0, then HUNT drops unsynced beats, then relock
        vecs.push_back(mk(0, 1, 0, 8'h99, 0, 8'h00, 0, 3'd0, 0, 1, 0, 3'd0, 8'h10));
        vecs.push_back(mk(0, 1, 0, 8'hAA, 0, 8'h00, 0, 3'd0, 0, 0, 0, 3'd0, 8'h10));
        vecs.push_back(mk(0, 1, 0, 8'hBB, 0, 8'h00, 0, 3'd0, 0, 0, 0, 3'd1, 8'h11));
        vecs.push_back(mk(0, 1, 1, 8'h01, 0, 8'h01, 0, 3'd1, 1, 0, 0, 3'd0, 8'h01));
        // Partial frame, early sync, then 7 more beats complete the new frame
        for (int k = 1; k < 4; k++) begin
            vecs.push_back(mk(0, 1, 0, 8'(8'h20 + k), 0, 8'(1 << k), 0, 3'(k + 1), 1, 0, 0,
                              3'(k), 8'(8'h20 + k)));
        end
        vecs.push_back(mk(0, 1, 1, 8'h55, 0, 8'h01, 0, 3'd1, 1, 1, 0, 3'd0, 8'h55));
        for (int k = 1; k < 8; k++) begin
            vecs.push_back(mk(0, 1, 0, 8'(8'h30 + k), 0, 8'(1 << k), k == 7, 3'(k + 1), 1, 0, 0,
                              3'(k), 8'(8'h30 + k)));
        end
        // Missing sync after a full frame: lane 0 untouched
        vecs.push_back(mk(0, 1, 0, 8'h66, 0, 8'h00, 0, 3'd0, 0, 1, 0, 3'd0, 8'h55));
        // Reset mid-frame, a beat during reset is ignored
        vecs.push_back(mk(0, 1, 1, 8'h40, 0, 8'h01, 0, 3'd1, 1, 0, 0, 3'd0, 8'h40));
        vecs.push_back(mk(0, 1, 0, 8'h41, 0, 8'h02, 0, 3'd2, 1, 0, 0, 3'd1, 8'h41));
        vecs.push_back(mk(1, 1, 1, 8'h77, 0, 8'h00, 0, 3'd0, 0, 0, 0, 3'd0, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 3'd0, 0, 0, 0, 3'd1, 8'h00));
        // Early sync landing exactly on slot 7: no lane 7 write, no frame_vld
        for (int k = 0; k < 7; k++) begin
            vecs.push_back(mk(0, 1, k == 0, 8'(8'h80 + k), 0, 8'(1 << k), 0, 3'(k + 1), 1, 0, 0,
                              3'(k), 8'(8'h80 + k)));
        end
        vecs.push_back(mk(0, 1, 1, 8'h88, 0, 8'h01, 0, 3'd1, 1, 1, 0, 3'd0, 8'h88));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 3'd1, 1, 0, 0, 3'd7, 8'h00));
`ifdef TDM_DEMUX_PARITY_EN
        // Bad parity on slot 3 kills that frame; the next clean frame completes
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 3'd0, 0, 0, 0, 3'd0, 8'h00));
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(0, 1, k == 0, 8'(8'h50 + k), k == 3, (k == 3) ? 8'h00 : 8'(1 << k),
                              0, 3'(k + 1), 1, 0, k == 3, 3'(k),
                              (k == 3) ? 8'h00 : 8'(8'h50 + k)));
        end
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(0, 1, k == 0, 8'(8'h60 + k), 0, 8'(1 << k), k == 7, 3'(k + 1), 1, 0,
                              0, 3'(k), 8'(8'h60 + k)));
        end
`endif

        rst            = 1'b1;
        bus_if.din     = '0;
        bus_if.din_vld = 1'b0;
        bus_if.fsync   = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        bus_if.din_par = 1'b0;
`endif
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            rst            = vecs[i].rst;
            bus_if.din_vld = vecs[i].vld;
            bus_if.fsync   = vecs[i].fs;
            bus_if.din     = vecs[i].din;
`ifdef TDM_DEMUX_PARITY_EN
            bus_if.din_par = (^vecs[i].din) ^ vecs[i].bad;
`endif
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e    = exp_q.pop_front();
            lane = e.e_lane;
            chk($sformatf("row%0d lane_vld", i), 64'(bus_if.lane_vld), 64'(e.e_lv));
            chk($sformatf("row%0d frame_vld", i), 64'(bus_if.frame_vld), 64'(e.e_fv));
            chk($sformatf("row%0d slot", i), 64'(bus_if.slot), 64'(e.e_slot));
            chk($sformatf("row%0d locked", i), 64'(bus_if.locked), 64'(e.e_lk));
            chk($sformatf("row%0d sync_err", i), 64'(bus_if.sync_err), 64'(e.e_se));
            chk($sformatf("row%0d lane%0d", i, lane), 64'(bus_if.dout[lane*8 +: 8]),
                64'(e.e_val));
            if (e.chk_dout) chk($sformatf("row%0d dout", i), bus_if.dout, e.e_dout);
`ifdef TDM_DEMUX_PARITY_EN
            chk($sformatf("row%0d par_err", i), 64'(bus_if.par_err), 64'(e.e_pe));
`endif
            bus_if.din_vld = 1'b0;
            bus_if.fsync   = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
